// File: rtl/debug_overlay_snap.sv
// Debug overlay: shows CHANNELS fixed-point vectors as a bit-grid in the top-right corner.
// The vectors are sampled once per frame into a snapshot bank, which can be frozen.
module debug_overlay_snap #(
   parameter int unsigned H_VIEW      = 640,
   parameter int unsigned DEBUG_SCALE = 3,
   parameter int unsigned WIDTH       = 16,
   parameter int unsigned INT_BITS    = 6,
   parameter int unsigned CHANNELS    = 6,
   parameter int unsigned GROUP       = 2
) (
   input  logic                         clk,
   input  logic                         reset,
   input  logic [9:0]                   hpos,
   input  logic [9:0]                   vpos,
   input  logic                         frame_start,
   input  logic                         freeze,
   input  logic                         show,
   input  logic [CHANNELS*WIDTH-1:0]    vectors,
   output logic                         snapshot_valid,
   output logic                         in_debug_overlay,
   output logic [5:0]                   debug_rgb
);

   localparam int unsigned START = H_VIEW - (WIDTH << DEBUG_SCALE) - 1;
   localparam int unsigned ROWS  = CHANNELS + (CHANNELS - 1) / GROUP;
   localparam int unsigned SW    = $clog2(GROUP + 1);
   localparam int unsigned CW    = $clog2(CHANNELS + 1);

   localparam logic [SW-1:0] GROUP_S   = SW'(GROUP);
   localparam logic [CW-1:0] CHAN_S    = CW'(CHANNELS);
   localparam logic [10:0]   V_LIMIT   = 11'(ROWS << DEBUG_SCALE);
   localparam logic [10:0]   DIVIDER_H = 11'(INT_BITS << DEBUG_SCALE);

   logic [CHANNELS-1:0][WIDTH-1:0] bank_q;
   logic [SW-1:0]                  slot_q, slot_d;
   logic [CW-1:0]                  chan_q, chan_d;

   logic [10:0]      h;
   logic [10:0]      col;
   logic             region;
   logic             gridline;
   logic             data_row;
   logic [WIDTH-1:0] row_bits;
   logic             cell_bit;
   logic [1:0]       c;

   // Snapshot bank
   always_ff @(posedge clk) begin
      if (reset) begin
         bank_q         <= '0;
         snapshot_valid <= 1'b0;
      end else if (frame_start && !freeze) begin
         bank_q         <= vectors;
         snapshot_valid <= 1'b1;
      end
   end

   // Row tracker: slot walks 0..GROUP (GROUP is the spacer), chan saturates at CHANNELS
   always_comb begin
      slot_d = slot_q;
      chan_d = chan_q;
      if (hpos == '0) begin
         if (vpos == '0) begin
            slot_d = '0;
            chan_d = '0;
         end else if (vpos[DEBUG_SCALE-1:0] == '0) begin
            if (slot_q < GROUP_S && chan_q < CHAN_S) begin
               chan_d = chan_q + CW'(1);
            end
            slot_d = (slot_q == GROUP_S) ? '0 : slot_q + SW'(1);
         end
      end
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         slot_q <= '0;
         chan_q <= '0;
      end else begin
         slot_q <= slot_d;
         chan_q <= chan_d;
      end
   end

   // h is negative (MSB set) left of the grid; hpos < 1024 keeps it in range
   assign h   = {1'b0, hpos} - 11'(START);
   assign col = h >> DEBUG_SCALE;

   always_comb begin
      region   = show && !h[10] && ({1'b0, vpos} <= V_LIMIT);
      gridline = (h[DEBUG_SCALE-1:0] == '0) || (vpos[DEBUG_SCALE-1:0] == '0);
      data_row = (slot_q < GROUP_S) && (chan_q < CHAN_S);

      row_bits = '0;
      for (int i = 0; i < int'(CHANNELS); i++) begin
         if (chan_q == CW'(i)) row_bits = bank_q[i];
      end

      // Column 0 shows the MSB; columns past the vector read as 0
      cell_bit = 1'b0;
      for (int j = 0; j < int'(WIDTH); j++) begin
         if (col == 11'(int'(WIDTH) - 1 - j)) cell_bit = row_bits[j];
      end

      if (gridline) begin
         c = (h == DIVIDER_H) ? 2'b10 : 2'b00;
      end else if (!data_row) begin
         c = 2'b00;
      end else begin
         c = cell_bit ? 2'b11 : 2'b01;
      end
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         in_debug_overlay <= 1'b0;
         debug_rgb        <= '0;
      end else begin
         in_debug_overlay <= region;
         debug_rgb        <= region ? {c, c, c} : 6'd0;
      end
   end

endmodule

// File: tb/tb_debug_overlay_snap.sv
// Self-checking bench for debug_overlay_snap: default build plus a CHANNELS=5, GROUP=3 build,
// both driven by the same raster stimulus and checked against a behavioural scoreboard model.
module tb_debug_overlay_snap;

   logic        clk = 1'b0;
   logic        reset = 1'b1;
   logic [9:0]  hpos = '0;
   logic [9:0]  vpos = '0;
   logic        frame_start = 1'b0;
   logic        freeze = 1'b0;
   logic        show = 1'b1;
   logic [95:0] vectors_a = '0;
   logic [79:0] vectors_b = '0;

   logic       valid_a, ovl_a, valid_b, ovl_b;
   logic [5:0] rgb_a, rgb_b;

   int n_cmp  = 0;
   int n_fail = 0;

   logic [15:0] bank_a [16];
   logic [15:0] bank_b [16];
   logic        val_a, val_b;
   logic [6:0]  exp_q_a [$];
   logic [6:0]  exp_q_b [$];

   always #5 clk = ~clk;

   debug_overlay_snap dut_a (
      .clk              (clk),
      .reset            (reset),
      .hpos             (hpos),
      .vpos             (vpos),
      .frame_start      (frame_start),
      .freeze           (freeze),
      .show             (show),
      .vectors          (vectors_a),
      .snapshot_valid   (valid_a),
      .in_debug_overlay (ovl_a),
      .debug_rgb        (rgb_a)
   );

   debug_overlay_snap #(
      .CHANNELS (5),
      .GROUP    (3)
   ) dut_b (
      .clk              (clk),
      .reset            (reset),
      .hpos             (hpos),
      .vpos             (vpos),
      .frame_start      (frame_start),
      .freeze           (freeze),
      .show             (show),
      .vectors          (vectors_b),
      .snapshot_valid   (valid_b),
      .in_debug_overlay (ovl_b),
      .debug_rgb        (rgb_b)
   );

   // Expected {in_debug_overlay, debug_rgb}; rows derived arithmetically from vpos
   function automatic logic [6:0] model(input bit which, input logic [9:0] hp, input logic [9:0] vp,
                                        input logic sh, input logic rs);
      int chans, grp, h, v, rows, r, slot, ch, col;
      logic [1:0]  c;
      logic [15:0] w;
      chans = which ? 5 : 6;
      grp   = which ? 3 : 2;
      if (rs) return 7'd0;
      h    = int'(hp) - 511;
      v    = int'(vp);
      rows = chans + (chans - 1) / grp;
      if (!sh || h < 0 || v > rows * 8) return 7'd0;
      if (h % 8 == 0 || v % 8 == 0) begin
         c = (h == 48) ? 2'b10 : 2'b00;
      end else begin
         r    = v / 8;
         slot = r % (grp + 1);
         ch   = (r / (grp + 1)) * grp + slot;
         if (slot == grp || ch >= chans) begin
            c = 2'b00;
         end else begin
            w   = which ? bank_b[ch] : bank_a[ch];
            col = h / 8;
            if (col > 15) c = 2'b01;
            else c = w[15 - col] ? 2'b11 : 2'b01;
         end
      end
      return {1'b1, c, c, c};
   endfunction

   task automatic step(input logic [9:0] hp, input logic [9:0] vp, input logic fs,
                       input logic fr, input logic sh, input logic rs, input string tag);
      logic [6:0] ea, eb;
      hpos = hp; vpos = vp; frame_start = fs; freeze = fr; show = sh; reset = rs;
      exp_q_a.push_back(model(1'b0, hp, vp, sh, rs));
      exp_q_b.push_back(model(1'b1, hp, vp, sh, rs));
      if (rs) begin
         for (int i = 0; i < 16; i++) begin
            bank_a[i] = '0;
            bank_b[i] = '0;
         end
         val_a = 1'b0;
         val_b = 1'b0;
      end else if (fs && !fr) begin
         for (int i = 0; i < 6; i++) bank_a[i] = vectors_a[i*16 +: 16];
         for (int i = 0; i < 5; i++) bank_b[i] = vectors_b[i*16 +: 16];
         val_a = 1'b1;
         val_b = 1'b1;
      end
      @(posedge clk);
      #1;
      ea = exp_q_a.pop_front();
      eb = exp_q_b.pop_front();
      n_cmp += 4;
      if ({ovl_a, rgb_a} !== ea) begin
         n_fail++;
         $display("FAIL %s.a hpos=%0d vpos=%0d got ovl/rgb=%b/%h want %b/%h",
                  tag, hp, vp, ovl_a, rgb_a, ea[6], ea[5:0]);
      end
      if ({ovl_b, rgb_b} !== eb) begin
         n_fail++;
         $display("FAIL %s.b hpos=%0d vpos=%0d got ovl/rgb=%b/%h want %b/%h",
                  tag, hp, vp, ovl_b, rgb_b, eb[6], eb[5:0]);
      end
      if (valid_a !== val_a) begin
         n_fail++;
         $display("FAIL %s.valid_a got %b want %b", tag, valid_a, val_a);
      end
      if (valid_b !== val_b) begin
         n_fail++;
         $display("FAIL %s.valid_b got %b want %b", tag, valid_b, val_b);
      end
   endtask

   // Raster-ordered scan: each line starts with an hpos=0 cycle so the row tracker advances
   task automatic scan(input int vmax, input logic sh, input string tag);
      logic [9:0] cols [6];
      cols = '{10'd516, 10'd523, 10'd524, 10'd559, 10'd636, 10'd639};
      for (int v = 0; v <= vmax; v++) begin
         step(10'd0, 10'(v), 1'b0, 1'b0, sh, 1'b0, tag);
         for (int k = 0; k < 6; k++) step(cols[k], 10'(v), 1'b0, 1'b0, sh, 1'b0, tag);
      end
   endtask

   task automatic test_reset;
      step(10'd0, 10'd0, 1'b0, 1'b0, 1'b1, 1'b1, "reset");
      step(10'd520, 10'd3, 1'b0, 1'b0, 1'b1, 1'b1, "reset");
      n_cmp++;
      if (rgb_a !== 6'd0 || ovl_a !== 1'b0 || valid_a !== 1'b0) begin
         n_fail++;
         $display("FAIL reset_state got rgb=%h ovl=%b valid=%b want 0/0/0", rgb_a, ovl_a, valid_a);
      end
      step(10'd0, 10'd0, 1'b0, 1'b0, 1'b1, 1'b0, "reset_release");
   endtask

   task automatic test_snapshot;
      vectors_a = {16'hC3C3, 16'h5555, 16'hAAAA, 16'h1234, 16'h00FF, 16'h8001};
      vectors_b = {16'hFFFF, 16'h1248, 16'h8421, 16'h0FF0, 16'hF00F};
      step(10'd0, 10'd0, 1'b1, 1'b0, 1'b1, 1'b0, "snap_load");
      scan(7, 1'b1, "snap_row0");
      step(10'd516, 10'd3, 1'b0, 1'b0, 1'b1, 1'b0, "snap_col0");
      n_cmp++;
      if (rgb_a !== 6'h3F) begin
         n_fail++;
         $display("FAIL snap_col0 got %h want 3f", rgb_a);
      end
      step(10'd524, 10'd3, 1'b0, 1'b0, 1'b1, 1'b0, "snap_col1");
      n_cmp++;
      if (rgb_a !== 6'h15) begin
         n_fail++;
         $display("FAIL snap_col1 got %h want 15", rgb_a);
      end
      step(10'd636, 10'd3, 1'b0, 1'b0, 1'b1, 1'b0, "snap_col15");
      n_cmp++;
      if (rgb_a !== 6'h3F) begin
         n_fail++;
         $display("FAIL snap_col15 got %h want 3f", rgb_a);
      end
   endtask

   task automatic test_rows;
      scan(70, 1'b1, "rows");
      step(10'd0, 10'd0, 1'b0, 1'b0, 1'b1, 1'b0, "grid_line0");
      step(10'd559, 10'd3, 1'b0, 1'b0, 1'b1, 1'b0, "grid_divider");
      n_cmp++;
      if (rgb_a !== 6'h2A) begin
         n_fail++;
         $display("FAIL grid_divider got %h want 2a", rgb_a);
      end
      step(10'd519, 10'd3, 1'b0, 1'b0, 1'b1, 1'b0, "grid_plain");
      n_cmp++;
      if (rgb_a !== 6'h00 || ovl_a !== 1'b1) begin
         n_fail++;
         $display("FAIL grid_plain got rgb=%h ovl=%b want 00/1", rgb_a, ovl_a);
      end
   endtask

   task automatic test_freeze;
      vectors_a[31:16] = 16'hFF00;
      step(10'd0, 10'd0, 1'b1, 1'b1, 1'b1, 1'b0, "freeze_blocked");
      scan(15, 1'b1, "frozen");
      step(10'd516, 10'd9, 1'b0, 1'b0, 1'b1, 1'b0, "frozen_ch1");
      n_cmp++;
      if (rgb_a !== 6'h15) begin
         n_fail++;
         $display("FAIL frozen_ch1 got %h want 15", rgb_a);
      end
      step(10'd0, 10'd0, 1'b1, 1'b0, 1'b1, 1'b0, "freeze_release");
      scan(15, 1'b1, "unfrozen");
      step(10'd516, 10'd9, 1'b0, 1'b0, 1'b1, 1'b0, "unfrozen_ch1");
      n_cmp++;
      if (rgb_a !== 6'h3F) begin
         n_fail++;
         $display("FAIL unfrozen_ch1 got %h want 3f", rgb_a);
      end
   endtask

   task automatic test_show;
      scan(9, 1'b0, "show_off");
      step(10'd516, 10'd3, 1'b0, 1'b0, 1'b0, 1'b0, "show_off_px");
      n_cmp++;
      if (ovl_a !== 1'b0 || rgb_a !== 6'd0) begin
         n_fail++;
         $display("FAIL show_off_px got ovl=%b rgb=%h want 0/00", ovl_a, rgb_a);
      end
   endtask

   task automatic test_reset_with_frame_start;
      step(10'd0, 10'd0, 1'b1, 1'b0, 1'b1, 1'b1, "rst_fs");
      n_cmp++;
      if (valid_a !== 1'b0 || valid_b !== 1'b0) begin
         n_fail++;
         $display("FAIL rst_fs_valid got %b/%b want 0/0", valid_a, valid_b);
      end
      scan(15, 1'b1, "rst_fs_bank");
   endtask

   initial begin
      for (int i = 0; i < 16; i++) begin
         bank_a[i] = '0;
         bank_b[i] = '0;
      end
      val_a = 1'b0;
      val_b = 1'b0;
      test_reset();
      test_snapshot();
      test_rows();
      test_freeze();
      test_show();
      test_reset_with_frame_start();
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
      $finish;
   end

   initial begin
      #2000000;
      $display("FAIL watchdog expired after %0d compares", n_cmp);
      $fatal(1);
   end

endmodule
